// File: rtl/gate_pair_checker.sv
// Stimulus-and-check controller for a NAND/NOR gate pair: walks a,b through
// 00..11, waits SETTLE cycles per vector, then compares t0/t1 to the truth table.
module gate_pair_checker #(
  parameter int SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       t0,
  input  logic       t1,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     state;
  logic [1:0] vec;
  logic [7:0] cnt;
  logic       mismatch;
  logic [2:0] err_next;

  assign a = vec[1];
  assign b = vec[0];

  // Both outputs wrong on one vector still counts as a single failing vector.
  always_comb begin
    mismatch = (t0 != ~(a & b)) || (t1 != ~(a | b));
    err_next = err_count + {2'b00, mismatch};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_vec  <= 4'd0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= 2'd0;
            cnt       <= 8'd0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            fail_vec[vec] <= 1'b1;
            err_count     <= err_next;
          end
          if (vec != 2'd3) begin
            vec   <= vec + 2'd1;
            cnt   <= 8'd0;
            state <= WAIT;
          end else begin
            vec   <= 2'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 3'd0);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/gate_pair_checker.md
# gate_pair_checker

Sequential stimulus-and-check controller for a two-input gate pair whose outputs are t0 = NAND(a, b) and t1 = NOR(a, b). It drives the four input vectors 00, 01, 10, 11 onto the device under test, waits a programmable settle time after each one, samples t0/t1 and compares them with the expected truth table. Errors are counted and recorded per vector. It is the driving end of the same a/b -> t0/t1 interface and is used on the lab board and in self-checking simulation.

## Interface
- SETTLE, default 4: cycles each vector is held before the check cycle; legal range 1..255.
- clk  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; accepted only in IDLE or DONE.
- t0  input  1  NAND output returned from the device under test.
- t1  input  1  NOR output returned from the device under test.
- a  output  1  stimulus bit, equal to vec[1].
- b  output  1  stimulus bit, equal to vec[0].
- busy  output  1  high from the start-accept edge until the DONE entry edge.
- done  output  1  high in DONE; holds until the next accepted start or reset.
- pass  output  1  high in DONE when err_count == 0.
- err_count  output  3  number of failing vectors, 0..4.
- fail_vec  output  4  bit i set when vector i (a,b = i[1], i[0]) mismatched.

## Operation
- Registered state:
  - FSM: IDLE, WAIT, CHECK, DONE.
  - vec[1:0].
  - cnt[7:0].
  - err_count, fail_vec.
- Every output is registered; a and b come straight from vec flops.
- IDLE or DONE, start = 1:
  - vec <= 0; cnt <= 0; err_count <= 0; fail_vec <= 0.
  - busy <= 1; done <= 0; pass <= 0; state <= WAIT.
- WAIT:
  - cnt increments each cycle.
  - When cnt == SETTLE-1: state <= CHECK.
- CHECK, on the exiting edge, t0 and t1 are compared with ~(a & b) and ~(a | b).
  - Either mismatch: fail_vec[vec] <= 1 and err_count += 1. There is at most one increment per vector, even if both outputs mismatch.
  - vec != 3: vec += 1, cnt <= 0, state <= WAIT.
  - vec == 3: vec <= 0 (a,b return to 00), busy <= 0, done <= 1, pass <= (final err_count == 0), state <= DONE.
- start is ignored while busy. It is not queued.
- start held high through DONE begins a new run on the next edge. Runs repeat back to back.
- t0 and t1 are only observed in CHECK. Their values in other states have no effect.
- err_count cannot overflow: its maximum is 4.

## Timing
- Reset values (rst high, asynchronous): state IDLE; a = b = 0; busy = done = pass = 0; err_count = 0; fail_vec = 0; cnt = 0.
- Reset asserted mid-run clears everything immediately, without waiting for a clock edge, and aborts the run. No partial results are kept.
- start accepted at edge k:
  - Vector 0 is driven from edge k.
  - Each vector occupies exactly SETTLE+1 cycles: SETTLE in WAIT, then 1 in CHECK.
  - Vector n is driven from edge k + n·(SETTLE+1).
  - Vector n is sampled at edge k + (n+1)·(SETTLE+1).
- done rises, and busy falls, at edge k + 4·(SETTLE+1). With SETTLE = 4 this is edge k+20.
- The device under test must settle within SETTLE cycles of an a/b change.
- In DONE, start at edge m clears done and pass at edge m and drives vector 0 from edge m.

## Test plan
- Reset: hold rst for 3 cycles with random t0/t1 -> a = b = busy = done = pass = 0, err_count = 0, fail_vec = 0000. Deassert rst with start = 0 -> outputs stay 0.
- Good device (t0 = ~(a&b), t1 = ~(a|b), combinational), SETTLE = 4, one-cycle start at edge k:
  - a,b = 00, 01, 10, 11, each held 5 cycles.
  - At edge k+20: done = 1, busy = 0, pass = 1, err_count = 0, fail_vec = 0000, a,b = 00.
- Faulty devices, one run each:
  - t1 stuck at 0 -> err_count = 1, fail_vec = 0001, pass = 0.
  - t0 stuck at 1 -> err_count = 1, fail_vec = 1000.
  - t0/t1 swapped -> vectors 01 and 10 fail, err_count = 2, fail_vec = 0110.
  - Both outputs inverted -> err_count = 4, fail_vec = 1111.
- start handling:
  - start pulses at edges k+3 and k+12 -> ignored; done still at k+20.
  - start held high continuously -> done high for exactly 1 cycle every 21 cycles, and results reflect each run.
- Mid-run reset: assert rst while vec = 2 -> all outputs 0 immediately. Release rst, pulse start -> a full 20-cycle run with correct results.
- SETTLE = 1 with the good device -> each vector held 2 cycles, done at edge k+8, pass = 1.
